// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared scoreboard entry type and forwarding-select encoding
package hazard_pkg;

    // Addresses are stored zero-extended to this width so the entry type is fixed.
    localparam int MAX_RAW = 8;
    localparam int FWD_RF  = 0;

    typedef struct packed {
        logic               valid;
        logic [MAX_RAW-1:0] ra1;
        logic [MAX_RAW-1:0] ra2;
        logic               use1;
        logic               use2;
        logic [MAX_RAW-1:0] wa_a;
        logic               we_a;
        logic [MAX_RAW-1:0] wa_b;
        logic               we_b;
        logic               is_load;
    } sb_entry_t;

    function automatic int fwd_sel_enc(input int stage, input logic port_b);
        return port_b ? 2 * stage : 2 * stage - 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// rtl/hazard_scoreboard_fwd_select.sv - youngest-wins forwarding search for one E-stage source
module fwd_select
    import hazard_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = 3
) (
    input  logic [MAX_RAW-1:0]        src,
    input  logic                      src_used,
    input  sb_entry_t [DEPTH-1:0]     ents,
    output logic [SEL_W-1:0]          sel
);

    logic unused_fields;

    // Scan oldest to youngest so the youngest match overwrites; port A is checked last per stage.
    always_comb begin
        sel = SEL_W'(FWD_RF);
        if (src_used) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (ents[k-1].valid && ents[k-1].we_b && ents[k-1].wa_b == src)
                    sel = SEL_W'(fwd_sel_enc(k, 1'b1));
                if (ents[k-1].valid && ents[k-1].we_a && ents[k-1].wa_a == src &&
                    (!ents[k-1].is_load || k >= LOAD_STAGE))
                    sel = SEL_W'(fwd_sel_enc(k, 1'b0));
            end
        end
    end

    always_comb begin
        unused_fields = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            unused_fields = unused_fields ^ (^{ents[k].ra1, ents[k].ra2, ents[k].use1, ents[k].use2});
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination scoreboard driving forwarding, load-use stall and flush
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int  RAW        = 3,
    parameter int  DEPTH      = 2,
    parameter int  LOAD_STAGE = 2,
    parameter int  CNT_W      = 16,
    localparam int SEL_W      = $clog2(2 * DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [RAW-1:0]   dec_ra1,
    input  logic [RAW-1:0]   dec_ra2,
    input  logic             dec_use1,
    input  logic             dec_use2,
    input  logic [RAW-1:0]   dec_wa_a,
    input  logic [RAW-1:0]   dec_wa_b,
    input  logic             dec_we_a,
    input  logic             dec_we_b,
    input  logic             dec_is_load,
    input  logic             ex_condex,
    input  logic             ex_branch_taken,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [CNT_W-1:0] stall_cnt
);

    sb_entry_t [DEPTH:0] sb;
    sb_entry_t           d_entry;
    sb_entry_t           e_adv;
    logic                lu;
    logic                flush_e_raw;
    logic [CNT_W-1:0]    cnt;
    logic [SEL_W-1:0]    sel_a;
    logic [SEL_W-1:0]    sel_b;

    assign flush_e_raw = ex_branch_taken | lu;

    always_comb begin
        d_entry         = '0;
        d_entry.valid   = dec_valid & ~flush_e_raw;
        d_entry.ra1     = MAX_RAW'(dec_ra1);
        d_entry.ra2     = MAX_RAW'(dec_ra2);
        d_entry.use1    = dec_use1;
        d_entry.use2    = dec_use2;
        d_entry.wa_a    = MAX_RAW'(dec_wa_a);
        d_entry.we_a    = dec_we_a;
        d_entry.wa_b    = MAX_RAW'(dec_wa_b);
        d_entry.we_b    = dec_we_b;
        d_entry.is_load = dec_is_load;
    end

    always_comb begin
        e_adv      = sb[0];
        e_adv.we_a = sb[0].we_a & ex_condex;
        e_adv.we_b = sb[0].we_b & ex_condex;
    end

    // Loads younger than LOAD_STAGE cannot forward yet; entry 0 still needs its condition qualified.
    always_comb begin
        lu = 1'b0;
        for (int p = 0; p < LOAD_STAGE - 1; p++) begin
            if (sb[p].valid && sb[p].is_load && sb[p].we_a && (p != 0 || ex_condex) &&
                ((dec_use1 && sb[p].wa_a == MAX_RAW'(dec_ra1)) ||
                 (dec_use2 && sb[p].wa_a == MAX_RAW'(dec_ra2))))
                lu = 1'b1;
        end
        lu = lu & dec_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb  <= '0;
            cnt <= '0;
        end else begin
            sb[0] <= d_entry;
            sb[1] <= e_adv;
            for (int k = 2; k <= DEPTH; k++)
                sb[k] <= sb[k-1];
            if (lu && !ex_branch_taken && cnt != {CNT_W{1'b1}})
                cnt <= cnt + 1'b1;
        end
    end

    fwd_select #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) u_fwd_a (
        .src      (sb[0].ra1),
        .src_used (sb[0].valid & sb[0].use1),
        .ents     (sb[DEPTH:1]),
        .sel      (sel_a)
    );

    fwd_select #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) u_fwd_b (
        .src      (sb[0].ra2),
        .src_used (sb[0].valid & sb[0].use2),
        .ents     (sb[DEPTH:1]),
        .sel      (sel_b)
    );

    assign fwd_a_sel = reset ? '0 : sel_a;
    assign fwd_b_sel = reset ? '0 : sel_b;
    assign stall_f   = ~reset & lu & ~ex_branch_taken;
    assign stall_d   = ~reset & lu & ~ex_branch_taken;
    assign flush_d   = ~reset & ex_branch_taken;
    assign flush_e   = ~reset & flush_e_raw;
    assign stall_cnt = reset ? '0 : cnt;

endmodule
